// File: rtl/trap_ctrl_pkg.sv
// Shared trap definitions: RISC-V cause encodings, interrupt priority and mcause layout.
// Imported by the trap sequencer and its interrupt selector.
package trap_ctrl_pkg;

    localparam int unsigned CoreXlen      = 64;
    localparam int unsigned McauseIntrBit = CoreXlen - 1;
    localparam int unsigned CauseW        = 6;
    localparam int unsigned IrqW          = 12;
    localparam int unsigned NumIrq        = 6;

    // rv_trap_t::exception
    typedef enum logic [CauseW-1:0] {
        ExcInstAddrMisaligned  = 6'd0,
        ExcInstAccessFault     = 6'd1,
        ExcInstIllegal         = 6'd2,
        ExcBreakpoint          = 6'd3,
        ExcLoadAddrMisaligned  = 6'd4,
        ExcLoadAccessFault     = 6'd5,
        ExcStoreAddrMisaligned = 6'd6,
        ExcStoreAccessFault    = 6'd7,
        ExcEcallU              = 6'd8,
        ExcEcallS              = 6'd9,
        ExcEcallM              = 6'd11,
        ExcInstPageFault       = 6'd12,
        ExcLoadPageFault       = 6'd13,
        ExcStorePageFault      = 6'd15
    } exc_cause_e;

    // rv_trap_t::interrupt
    typedef enum logic [CauseW-1:0] {
        IrqSSoft  = 6'd1,
        IrqMSoft  = 6'd3,
        IrqSTimer = 6'd5,
        IrqMTimer = 6'd7,
        IrqSExt   = 6'd9,
        IrqMExt   = 6'd11
    } irq_cause_e;

    // Highest priority first.
    localparam irq_cause_e IntPrio [NumIrq] = '{IrqMExt, IrqMSoft, IrqMTimer,
                                                IrqSExt, IrqSSoft, IrqSTimer};

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StUpdate,
        StRedirect
    } trap_state_e;

    // Codes outside the enum are reported as an illegal instruction.
    function automatic exc_cause_e legal_exc(input logic [CauseW-1:0] code);
        exc_cause_e res;
        case (code)
            ExcInstAddrMisaligned, ExcInstAccessFault, ExcInstIllegal, ExcBreakpoint,
            ExcLoadAddrMisaligned, ExcLoadAccessFault, ExcStoreAddrMisaligned,
            ExcStoreAccessFault, ExcEcallU, ExcEcallS, ExcEcallM, ExcInstPageFault,
            ExcLoadPageFault, ExcStorePageFault: res = exc_cause_e'(code);
            default:                             res = ExcInstIllegal;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit/CSR/fetch-facing signal bundle of the trap sequencer.
// slave = trap_ctrl side, master = the surrounding core (or a bench).
interface trap_ctrl_if #(
    parameter int unsigned XLEN = trap_ctrl_pkg::CoreXlen
);
    logic            i_exc_vld;
    logic [5:0]      i_exc_cause;
    logic [XLEN-1:0] i_exc_pc;
    logic [XLEN-1:0] i_exc_tval;
    logic            i_mret;
    logic            i_intr_allow;
    logic [XLEN-1:0] i_next_pc;
    logic [XLEN-1:0] i_mip;
    logic [XLEN-1:0] i_mie;
    logic            i_mstatus_mie;
    logic            i_mstatus_mpie;
    logic [XLEN-1:0] i_mtvec;
    logic [XLEN-1:0] i_mepc;
    logic            i_drained;
    logic            i_redirect_rdy;

    logic            o_busy;
    logic            o_flush;
    logic            o_csr_we;
    logic [XLEN-1:0] o_mepc;
    logic [XLEN-1:0] o_mcause;
    logic [XLEN-1:0] o_mtval;
    logic            o_mstatus_mie;
    logic            o_mstatus_mpie;
    logic            o_redirect_vld;
    logic [XLEN-1:0] o_redirect_pc;

    modport slave (
        input  i_exc_vld, i_exc_cause, i_exc_pc, i_exc_tval, i_mret, i_intr_allow,
               i_next_pc, i_mip, i_mie, i_mstatus_mie, i_mstatus_mpie, i_mtvec, i_mepc,
               i_drained, i_redirect_rdy,
        output o_busy, o_flush, o_csr_we, o_mepc, o_mcause, o_mtval, o_mstatus_mie,
               o_mstatus_mpie, o_redirect_vld, o_redirect_pc
    );

    modport master (
        output i_exc_vld, i_exc_cause, i_exc_pc, i_exc_tval, i_mret, i_intr_allow,
               i_next_pc, i_mip, i_mie, i_mstatus_mie, i_mstatus_mpie, i_mtvec, i_mepc,
               i_drained, i_redirect_rdy,
        input  o_busy, o_flush, o_csr_we, o_mepc, o_mcause, o_mtval, o_mstatus_mie,
               o_mstatus_mpie, o_redirect_vld, o_redirect_pc
    );
endinterface

// File: rtl/trap_prio_sel.sv
// Combinational machine/supervisor interrupt picker over the masked mip & mie bits.
// Walks the priority table lowest-first so the highest pending entry wins.
module trap_prio_sel
    import trap_ctrl_pkg::*;
(
    input  logic [IrqW-1:0]   mip_i,
    input  logic [IrqW-1:0]   mie_i,
    input  logic              en_i,
    output logic              vld_o,
    output logic [CauseW-1:0] cause_o
);

    logic [IrqW-1:0] pend;

    always_comb begin
        pend    = mip_i & mie_i & {IrqW{en_i}};
        vld_o   = 1'b0;
        cause_o = '0;
        for (int i = NumIrq - 1; i >= 0; i--) begin
            if (pend[IntPrio[i][3:0]]) begin
                vld_o   = 1'b1;
                cause_o = IntPrio[i];
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: captures one trap/interrupt/mret in IDLE, flushes,
// writes the trap CSRs for one cycle, then holds the redirect until fetch accepts it.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = CoreXlen
) (
    input logic         clk,
    input logic         rst,
    trap_ctrl_if.slave  bus
);

    trap_state_e state_q, state_d;

    // Event latched at capture; CSR values and target are fully resolved here.
    logic            lat_mret_q, lat_mret_d;
    logic [XLEN-1:0] lat_mepc_q, lat_mepc_d;
    logic [XLEN-1:0] lat_mcause_q, lat_mcause_d;
    logic [XLEN-1:0] lat_mtval_q, lat_mtval_d;
    logic [XLEN-1:0] lat_target_q, lat_target_d;
    logic            lat_mie_q, lat_mie_d;
    logic            lat_mpie_q, lat_mpie_d;

    logic            busy_q, busy_d;
    logic            flush_q, flush_d;
    logic            csr_we_q, csr_we_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            st_mie_q, st_mie_d;
    logic            st_mpie_q, st_mpie_d;
    logic            rvld_q, rvld_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic              irq_vld;
    logic [CauseW-1:0] irq_cause;
    exc_cause_e        exc_cause;
    logic [XLEN-1:0]   tvec_base;
    logic              unused_irq_hi;

    assign unused_irq_hi = ^{bus.i_mip[XLEN-1:IrqW], bus.i_mie[XLEN-1:IrqW]};

    trap_prio_sel u_prio_sel (
        .mip_i   (bus.i_mip[IrqW-1:0]),
        .mie_i   (bus.i_mie[IrqW-1:0]),
        .en_i    (bus.i_intr_allow & bus.i_mstatus_mie),
        .vld_o   (irq_vld),
        .cause_o (irq_cause)
    );

    assign exc_cause = legal_exc(bus.i_exc_cause);
    assign tvec_base = bus.i_mtvec & ~XLEN'(3);

    always_comb begin
        state_d      = state_q;
        lat_mret_d   = lat_mret_q;
        lat_mepc_d   = lat_mepc_q;
        lat_mcause_d = lat_mcause_q;
        lat_mtval_d  = lat_mtval_q;
        lat_target_d = lat_target_q;
        lat_mie_d    = lat_mie_q;
        lat_mpie_d   = lat_mpie_q;
        busy_d       = busy_q;
        flush_d      = flush_q;
        csr_we_d     = 1'b0;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        st_mie_d     = st_mie_q;
        st_mpie_d    = st_mpie_q;
        rvld_d       = rvld_q;
        rpc_d        = rpc_q;

        case (state_q)
            StIdle: begin
                if (irq_vld || bus.i_exc_vld || bus.i_mret) begin
                    state_d = StFlush;
                    busy_d  = 1'b1;
                    flush_d = 1'b1;
                    // A same-cycle exception loses to the interrupt and re-executes later.
                    if (irq_vld) begin
                        lat_mret_d   = 1'b0;
                        lat_mepc_d   = bus.i_next_pc;
                        lat_mcause_d = {1'b1, (XLEN-1)'(irq_cause)};
                        lat_mtval_d  = '0;
                        lat_mie_d    = 1'b0;
                        lat_mpie_d   = bus.i_mstatus_mie;
                        lat_target_d = (bus.i_mtvec[1:0] == 2'b01)
                                     ? tvec_base + XLEN'({irq_cause, 2'b00}) : tvec_base;
                    end else if (bus.i_exc_vld) begin
                        lat_mret_d   = 1'b0;
                        lat_mepc_d   = bus.i_exc_pc;
                        lat_mcause_d = XLEN'(exc_cause);
                        lat_mtval_d  = bus.i_exc_tval;
                        lat_mie_d    = 1'b0;
                        lat_mpie_d   = bus.i_mstatus_mie;
                        lat_target_d = tvec_base;
                    end else begin
                        lat_mret_d   = 1'b1;
                        lat_mie_d    = bus.i_mstatus_mpie;
                        lat_mpie_d   = 1'b1;
                        lat_target_d = bus.i_mepc & ~XLEN'(1);
                    end
                end
            end
            StFlush: begin
                if (bus.i_drained) begin
                    state_d   = StUpdate;
                    flush_d   = 1'b0;
                    csr_we_d  = 1'b1;
                    st_mie_d  = lat_mie_q;
                    st_mpie_d = lat_mpie_q;
                    // mret leaves the trap data outputs untouched.
                    if (!lat_mret_q) begin
                        mepc_d   = lat_mepc_q;
                        mcause_d = lat_mcause_q;
                        mtval_d  = lat_mtval_q;
                    end
                end
            end
            StUpdate: begin
                state_d = StRedirect;
                rvld_d  = 1'b1;
                rpc_d   = lat_target_q;
            end
            StRedirect: begin
                if (bus.i_redirect_rdy) begin
                    state_d = StIdle;
                    rvld_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            lat_mret_q   <= 1'b0;
            lat_mepc_q   <= '0;
            lat_mcause_q <= '0;
            lat_mtval_q  <= '0;
            lat_target_q <= '0;
            lat_mie_q    <= 1'b0;
            lat_mpie_q   <= 1'b0;
            busy_q       <= 1'b0;
            flush_q      <= 1'b0;
            csr_we_q     <= 1'b0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            st_mie_q     <= 1'b0;
            st_mpie_q    <= 1'b0;
            rvld_q       <= 1'b0;
            rpc_q        <= '0;
        end else begin
            state_q      <= state_d;
            lat_mret_q   <= lat_mret_d;
            lat_mepc_q   <= lat_mepc_d;
            lat_mcause_q <= lat_mcause_d;
            lat_mtval_q  <= lat_mtval_d;
            lat_target_q <= lat_target_d;
            lat_mie_q    <= lat_mie_d;
            lat_mpie_q   <= lat_mpie_d;
            busy_q       <= busy_d;
            flush_q      <= flush_d;
            csr_we_q     <= csr_we_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
            st_mie_q     <= st_mie_d;
            st_mpie_q    <= st_mpie_d;
            rvld_q       <= rvld_d;
            rpc_q        <= rpc_d;
        end
    end

    assign bus.o_busy         = busy_q;
    assign bus.o_flush        = flush_q;
    assign bus.o_csr_we       = csr_we_q;
    assign bus.o_mepc         = mepc_q;
    assign bus.o_mcause       = mcause_q;
    assign bus.o_mtval        = mtval_q;
    assign bus.o_mstatus_mie  = st_mie_q;
    assign bus.o_mstatus_mpie = st_mpie_q;
    assign bus.o_redirect_vld = rvld_q;
    assign bus.o_redirect_pc  = rpc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    trap_ctrl_if #(.XLEN(64)) bus ();

    trap_ctrl #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_events();
        bus.i_exc_vld   = 1'b0;
        bus.i_exc_cause = '0;
        bus.i_exc_pc    = '0;
        bus.i_exc_tval  = '0;
        bus.i_mret      = 1'b0;
        bus.i_mip       = '0;
        bus.i_mie       = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".busy"},   64'(bus.o_busy), 64'd0);
        check_val({tag, ".flush"},  64'(bus.o_flush), 64'd0);
        check_val({tag, ".csr_we"}, 64'(bus.o_csr_we), 64'd0);
        check_val({tag, ".mepc"},   bus.o_mepc, 64'd0);
        check_val({tag, ".mcause"}, bus.o_mcause, 64'd0);
        check_val({tag, ".mtval"},  bus.o_mtval, 64'd0);
        check_val({tag, ".mie"},    64'(bus.o_mstatus_mie), 64'd0);
        check_val({tag, ".mpie"},   64'(bus.o_mstatus_mpie), 64'd0);
        check_val({tag, ".rvld"},   64'(bus.o_redirect_vld), 64'd0);
        check_val({tag, ".rpc"},    bus.o_redirect_pc, 64'd0);
    endtask

    // Event already driven at the current falling edge, both handshakes high.
    // Returns on the first IDLE cycle's falling edge so a new event can follow at once.
    task automatic run_seq(input string tag, input logic [63:0] e_mepc, input logic [63:0] e_mcause,
                           input logic [63:0] e_mtval, input logic e_mie, input logic e_mpie,
                           input logic [63:0] e_pc);
        @(negedge clk);
        check_val({tag, ".flush_busy"}, {62'd0, bus.o_busy, bus.o_flush}, 64'd3);
        check_val({tag, ".we_early"}, 64'(bus.o_csr_we), 64'd0);
        clear_events();
        @(negedge clk);
        check_val({tag, ".we"},     {62'd0, bus.o_csr_we, bus.o_flush}, 64'd2);
        check_val({tag, ".mepc"},   bus.o_mepc, e_mepc);
        check_val({tag, ".mcause"}, bus.o_mcause, e_mcause);
        check_val({tag, ".mtval"},  bus.o_mtval, e_mtval);
        check_val({tag, ".status"}, {62'd0, bus.o_mstatus_mie, bus.o_mstatus_mpie},
                  {62'd0, e_mie, e_mpie});
        @(negedge clk);
        check_val({tag, ".rvld"}, {61'd0, bus.o_redirect_vld, bus.o_csr_we, bus.o_busy}, 64'd5);
        check_val({tag, ".rpc"},  bus.o_redirect_pc, e_pc);
        @(negedge clk);
        check_val({tag, ".done"}, {62'd0, bus.o_busy, bus.o_redirect_vld}, 64'd0);
    endtask

    int unsigned flush_cnt, we_cnt, rvld_cnt, busy_cnt;

    initial begin
        clear_events();
        bus.i_intr_allow   = 1'b0;
        bus.i_next_pc      = '0;
        bus.i_mstatus_mie  = 1'b0;
        bus.i_mstatus_mpie = 1'b0;
        bus.i_mtvec        = '0;
        bus.i_mepc         = '0;
        bus.i_drained      = 1'b1;
        bus.i_redirect_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Exception, direct mode.
        bus.i_exc_vld = 1'b1; bus.i_exc_cause = 6'd5;
        bus.i_exc_pc = 64'h8000_0100; bus.i_exc_tval = 64'h1234;
        bus.i_mtvec = 64'h8000_0000; bus.i_mstatus_mie = 1'b1; bus.i_mstatus_mpie = 1'b0;
        run_seq("exc", 64'h8000_0100, 64'd5, 64'h1234, 1'b0, 1'b1, 64'h8000_0000);

        // Interrupt beats same-cycle exception, vectored mode; accepted in the first IDLE cycle.
        bus.i_mip = (64'd1 << 7) | (64'd1 << 11); bus.i_mie = (64'd1 << 7) | (64'd1 << 11);
        bus.i_intr_allow = 1'b1; bus.i_mstatus_mie = 1'b1; bus.i_next_pc = 64'h8000_0400;
        bus.i_exc_vld = 1'b1; bus.i_exc_cause = 6'd2; bus.i_exc_pc = 64'h8000_0500;
        bus.i_exc_tval = 64'hdead; bus.i_mtvec = 64'h8000_0001;
        run_seq("irq", 64'h8000_0400, 64'h8000_0000_0000_000B, 64'd0, 1'b0, 1'b1,
                64'h8000_002C);
        @(negedge clk);
        check_val("irq.exc_dropped", 64'(bus.o_busy), 64'd0);

        // mret: status restored, trap data unchanged from the previous trap.
        bus.i_intr_allow = 1'b0; bus.i_mstatus_mie = 1'b0; bus.i_mstatus_mpie = 1'b1;
        bus.i_mret = 1'b1; bus.i_mepc = 64'h8000_0203;
        run_seq("mret", 64'h8000_0400, 64'h8000_0000_0000_000B, 64'd0, 1'b1, 1'b1,
                64'h8000_0202);

        // Stalled handshakes: drained low 5 flush cycles, redirect_rdy low 3 redirect cycles.
        bus.i_drained = 1'b0; bus.i_redirect_rdy = 1'b0; bus.i_mstatus_mie = 1'b1;
        bus.i_exc_vld = 1'b1; bus.i_exc_cause = 6'd13; bus.i_exc_pc = 64'h8000_0600;
        bus.i_exc_tval = 64'h77; bus.i_mtvec = 64'h8000_1000;
        flush_cnt = 0; we_cnt = 0; rvld_cnt = 0; busy_cnt = 0;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(negedge clk);
            if (cyc == 1) clear_events();
            if (bus.o_flush) flush_cnt++;
            if (bus.o_csr_we) begin
                we_cnt++;
                check_val("stall.mcause", bus.o_mcause, 64'd13);
            end
            if (bus.o_redirect_vld) begin
                rvld_cnt++;
                check_val("stall.rpc", bus.o_redirect_pc, 64'h8000_1000);
            end
            if (bus.o_busy) busy_cnt++;
            if (cyc == 6) bus.i_drained = 1'b1;
            if (cyc == 11) bus.i_redirect_rdy = 1'b1;
        end
        check_val("stall.flush_cnt", 64'(flush_cnt), 64'd6);
        check_val("stall.we_cnt",    64'(we_cnt), 64'd1);
        check_val("stall.rvld_cnt",  64'(rvld_cnt), 64'd4);
        check_val("stall.busy_cnt",  64'(busy_cnt), 64'd11);

        // Reset mid-sequence while in FLUSH.
        bus.i_drained = 1'b0;
        bus.i_exc_vld = 1'b1; bus.i_exc_cause = 6'd3; bus.i_exc_pc = 64'h8000_0700;
        @(negedge clk);
        check_val("rstmid.in_flush", 64'(bus.o_flush), 64'd1);
        clear_events();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("rstmid");
        rst = 1'b1; bus.i_drained = 1'b1; bus.i_redirect_rdy = 1'b1;
        @(negedge clk);
        check_val("rstmid.idle", 64'(bus.o_busy), 64'd0);

        // Fresh exception after reset; vectored mtvec still uses base for exceptions.
        bus.i_mstatus_mie = 1'b0; bus.i_mstatus_mpie = 1'b1;
        bus.i_exc_vld = 1'b1; bus.i_exc_cause = 6'd7; bus.i_exc_pc = 64'h8000_0300;
        bus.i_exc_tval = 64'hffff_ffff_ffff_fff0; bus.i_mtvec = 64'h8000_0101;
        run_seq("post_rst", 64'h8000_0300, 64'd7, 64'hffff_ffff_ffff_fff0, 1'b0, 1'b0,
                64'h8000_0100);

        // Unknown cause codes map to illegal instruction.
        bus.i_exc_vld = 1'b1; bus.i_exc_cause = 6'd30; bus.i_exc_pc = 64'h8000_0800;
        bus.i_exc_tval = 64'd0; bus.i_mtvec = 64'h8000_0000;
        run_seq("unk30", 64'h8000_0800, 64'd2, 64'd0, 1'b0, 1'b0, 64'h8000_0000);
        bus.i_exc_vld = 1'b1; bus.i_exc_cause = 6'd10; bus.i_exc_pc = 64'h8000_0804;
        run_seq("unk10", 64'h8000_0804, 64'd2, 64'd0, 1'b0, 1'b0, 64'h8000_0000);

        // Priority: mSoft beats mTimer and sExter, vectored target 0x8000_000C.
        bus.i_intr_allow = 1'b1; bus.i_mstatus_mie = 1'b1; bus.i_next_pc = 64'h8000_0900;
        bus.i_mip = (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 9) | (64'd1 << 11);
        bus.i_mie = (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 9);
        bus.i_mtvec = 64'h8000_0001;
        run_seq("irq_msoft", 64'h8000_0900, 64'h8000_0000_0000_0003, 64'd0, 1'b0, 1'b1,
                64'h8000_000C);

        // Interrupt pending with MIE=0 is ignored.
        bus.i_mstatus_mie = 1'b0;
        bus.i_mip = 64'd1 << 11; bus.i_mie = 64'd1 << 11;
        @(negedge clk);
        check_val("irq_masked", 64'(bus.o_busy), 64'd0);
        clear_events();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
